// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: CPU (port C) vs debug/DMA (port D) on a single-port, async-read DMEM.
// Define DMEM_ARB_LOCK_EN to enable the debug lock (LOCKED state); otherwise dbg_lock is ignored.
module dmem_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 10,
    parameter int MAX_WAIT = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wd,
    output logic [DATA_W-1:0] cpu_rd,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wd,
    input  logic              dbg_lock,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd
);

    // MAX_WAIT=0 would give a zero-width counter; keep at least one bit.
    localparam int CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

`ifdef DMEM_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    typedef enum logic {ARB, LOCKED} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic                dbg_rvalid_q;
    logic [DATA_W-1:0]   dbg_rdata_q;

    logic                locked;
    logic                force_dbg;
    logic                d_owns;
    logic                gnt;
    logic                rd_accept;

    always_comb begin
        // Dropping dbg_lock releases ownership in the same cycle.
        locked     = LOCK_EN && (state_q == LOCKED) && dbg_lock;
        force_dbg  = dbg_req && (wait_cnt_q == WAIT_MAX);
        d_owns     = locked || (dbg_req && (force_dbg || !cpu_req));
        gnt        = dbg_req && d_owns;
        rd_accept  = gnt && !dbg_we;

        wait_cnt_d = '0;
        if (dbg_req && !gnt) begin
            wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + CNT_W'(1);
        end

        state_d = ARB;
        if (LOCK_EN && dbg_lock && ((state_q == LOCKED) || gnt)) begin
            state_d = LOCKED;
        end
    end

    // Strobes are forced low while reset is held so nothing reaches the macro.
    assign cpu_stall  = reset_n & cpu_req & d_owns;
    assign dbg_gnt    = reset_n & gnt;
    assign mem_we     = reset_n & (d_owns ? (dbg_we & dbg_req) : (cpu_we & cpu_req));
    assign mem_addr   = (d_owns && dbg_req) ? dbg_addr : cpu_addr;
    assign mem_wd     = (d_owns && dbg_req) ? dbg_wd : cpu_wd;
    assign cpu_rd     = mem_rd;
    assign dbg_rvalid = dbg_rvalid_q;
    assign dbg_rdata  = dbg_rdata_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ARB;
            wait_cnt_q   <= '0;
            dbg_rvalid_q <= 1'b0;
            dbg_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            dbg_rvalid_q <= rd_accept;
            if (rd_accept) begin
                dbg_rdata_q <= mem_rd;
            end
        end
    end

endmodule
